// File: rtl/pla_sweep_ctrl.sv
// rtl/pla_sweep_ctrl.sv - exhaustive input sweeper and onset counter for one logic cone
//
// Purpose: walks a single-output logic function through every vector of the
// selected variable subspace (swept bits count up, held bits come from
// fixed_val), then reports how many vectors were sampled and how many gave y=1.
// Optional feature macro: PLA_SWEEP_SIG_EN adds a 16-bit MISR over the y stream.
//
// Parameters:
//   NIN        number of function inputs
//   PIPE       register stages between x and y in the function under test
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a run (sampled only in IDLE)
//   abort      terminate the current run, no done pulse
//   var_mask   1 = variable swept, 0 = variable held
//   fixed_val  values for held variables
//   x          vector applied to the function
//   y          function output
//   busy       run in progress (LOAD through DONE)
//   done       one-cycle pulse at normal completion
//   onset_cnt  sampled vectors with y=1
//   total_cnt  sampled vectors
//   signature  MISR of the y stream (PLA_SWEEP_SIG_EN only)

module pla_sweep_ctrl #(
  parameter int NIN  = 15,
  parameter int PIPE = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [NIN-1:0] var_mask,
  input  logic [NIN-1:0] fixed_val,
  output logic [NIN-1:0] x,
  output logic           busy,
  output logic           done,
  output logic [NIN:0]   onset_cnt,
  output logic [NIN:0]   total_cnt,
`ifdef PLA_SWEEP_SIG_EN
  output logic [15:0]    signature,
`endif
  input  logic           y
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  // Drain counter is never used when PIPE=0, but keep it at least one bit wide.
  localparam int DW = $clog2(PIPE + 2);

  state_t         state;
  logic [NIN-1:0] m;
  logic [NIN-1:0] f;
  logic [NIN-1:0] c;
  logic [NIN-1:0] c_next;
  logic [DW-1:0]  dcnt;
  logic           sample;

  // Masked increment: forcing held bits to 1 lets the carry ripple straight
  // through them, so only swept bits ever count. Wraps to 0 after the last vector.
  assign c_next = ((c | ~m) + NIN'(1)) & m;

  // A vector applied in SWEEP is sampled PIPE edges later; the shift register
  // marks which cycles carry a real vector at the function output.
  generate
    if (PIPE == 0) begin : g_nopipe
      assign sample = (state == S_SWEEP);
    end else begin : g_pipe
      logic [PIPE-1:0] vpipe;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vpipe <= '0;
        end else if (abort && state != S_IDLE) begin
          vpipe <= '0;
        end else begin
          vpipe <= (vpipe << 1) | PIPE'(state == S_SWEEP);
        end
      end
      assign sample = vpipe[PIPE-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      x         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      m         <= '0;
      f         <= '0;
      c         <= '0;
      dcnt      <= '0;
      onset_cnt <= '0;
      total_cnt <= '0;
    end else begin
      done <= 1'b0;

      // The sample landing on an abort edge still counts; only the pipe is flushed.
      if (state == S_LOAD) begin
        onset_cnt <= '0;
        total_cnt <= '0;
      end else if (sample) begin
        total_cnt <= total_cnt + (NIN+1)'(1);
        onset_cnt <= onset_cnt + {{NIN{1'b0}}, y};
      end

      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state <= S_LOAD;
            busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          m     <= var_mask;
          f     <= fixed_val;
          c     <= '0;
          x     <= fixed_val & ~var_mask;
          state <= S_SWEEP;
        end
        S_SWEEP: begin
          if (c_next == '0) begin
            // Current vector is the last; x keeps it through DRAIN/DONE/IDLE.
            if (PIPE == 0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAIN;
              dcnt  <= '0;
            end
          end else begin
            c <= c_next;
            x <= c_next | (f & ~m);
          end
        end
        S_DRAIN: begin
          if (dcnt == DW'(PIPE - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (abort && state != S_IDLE) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end
    end
  end

`ifdef PLA_SWEEP_SIG_EN
  // MISR, polynomial x^16+x^12+x^5+1, seeded to all ones at LOAD.
  logic sig_fb;
  assign sig_fb = signature[15] ^ y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signature <= 16'hFFFF;
    end else if (state == S_LOAD) begin
      signature <= 16'hFFFF;
    end else if (sample) begin
      signature <= {signature[14:0], 1'b0} ^ (sig_fb ? 16'h1021 : 16'h0000);
    end
  end
`else
  // Without the signature option only the counters observe y.
`endif

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// tb/tb_pla_sweep_ctrl.sv - scoreboard bench for pla_sweep_ctrl (PIPE=0 and PIPE=2 instances)

module tb_pla_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start0 = 1'b0, abort0 = 1'b0;
  logic [14:0] mask0 = '0, fix0 = '0, x0;
  logic        y0, busy0, done0, y_force = 1'b0;
  logic [15:0] on0, tot0;

  logic        start2 = 1'b0, abort2 = 1'b0;
  logic [14:0] mask2 = '0, fix2 = '0, x2;
  logic        y2, busy2, done2, p1 = 1'b0, p2 = 1'b0;
  logic [15:0] on2, tot2;
`ifdef PLA_SWEEP_SIG_EN
  logic [15:0] sig0, sig2;
`endif

  // Function models: y = x[0], combinational for dut0, two register stages for dut2.
  assign y0 = y_force | x0[0];
  always @(posedge clk) begin
    p1 <= x2[0];
    p2 <= p1;
  end
  assign y2 = p2;

  pla_sweep_ctrl #(.NIN(15), .PIPE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .var_mask(mask0), .fixed_val(fix0), .x(x0), .busy(busy0), .done(done0),
    .onset_cnt(on0), .total_cnt(tot0),
`ifdef PLA_SWEEP_SIG_EN
    .signature(sig0),
`endif
    .y(y0)
  );

  pla_sweep_ctrl #(.NIN(15), .PIPE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .var_mask(mask2), .fixed_val(fix2), .x(x2), .busy(busy2), .done(done2),
    .onset_cnt(on2), .total_cnt(tot2),
`ifdef PLA_SWEEP_SIG_EN
    .signature(sig2),
`endif
    .y(y2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic        busy;
    logic        chk_cnt;
    int          on;
    int          tot;
    logic        chk_x;
    int          xv;
  } chk_t;

  typedef struct {
    int          cyc;
    string       name;
    int          on;
    int          tot;
    logic        chk_sig;
    logic [15:0] sig;
  } done_t;

  chk_t  q0[$], q2[$];
  done_t d0[$], d2[$];
  int    rst_armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic chk_t mk(input int c, input string n, input logic b, input logic cc,
                              input int on, input int tot, input logic cx, input int xv);
    chk_t e;
    e.cyc = c; e.name = n; e.busy = b; e.chk_cnt = cc;
    e.on = on; e.tot = tot; e.chk_x = cx; e.xv = xv;
    return e;
  endfunction

  function automatic done_t mkd(input int c, input string n, input int on, input int tot,
                                input logic cs, input logic [15:0] s);
    done_t d;
    d.cyc = c; d.name = n; d.on = on; d.tot = tot; d.chk_sig = cs; d.sig = s;
    return d;
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
    logic fb;
    fb = s[15] ^ b;
    return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  task automatic mon_chk(input chk_t e, input logic b, input logic [15:0] on,
                         input logic [15:0] tot, input logic [14:0] xv);
    chk({e.name, "_busy"}, b, e.busy);
    if (e.chk_cnt) begin
      chk({e.name, "_onset"}, on, e.on);
      chk({e.name, "_total"}, tot, e.tot);
    end
    if (e.chk_x) chk({e.name, "_x"}, xv, e.xv);
  endtask

  // Monitors: cycle number of the interval being observed is cyc+1.
  always @(negedge clk) begin
    chk_t  e;
    done_t d;
    while (q0.size() > 0 && q0[0].cyc == cyc + 1) begin
      e = q0.pop_front();
      mon_chk(e, busy0, on0, tot0, x0);
    end
    if (done0 === 1'b1) begin
      if (d0.size() == 0) chk("done0_unexpected", done0, 0);
      else begin
        d = d0.pop_front();
        chk({d.name, "_done_cycle"}, cyc + 1, d.cyc);
        chk({d.name, "_onset"}, on0, d.on);
        chk({d.name, "_total"}, tot0, d.tot);
        chk({d.name, "_busy"}, busy0, 1);
`ifdef PLA_SWEEP_SIG_EN
        if (d.chk_sig) chk({d.name, "_sig"}, sig0, d.sig);
`endif
      end
    end
  end

  always @(negedge clk) begin
    chk_t  e;
    done_t d;
    while (q2.size() > 0 && q2[0].cyc == cyc + 1) begin
      e = q2.pop_front();
      mon_chk(e, busy2, on2, tot2, x2);
    end
    if (done2 === 1'b1) begin
      if (d2.size() == 0) chk("done2_unexpected", done2, 0);
      else begin
        d = d2.pop_front();
        chk({d.name, "_done_cycle"}, cyc + 1, d.cyc);
        chk({d.name, "_onset"}, on2, d.on);
        chk({d.name, "_total"}, tot2, d.tot);
        chk({d.name, "_busy"}, busy2, 1);
      end
    end
  end

  // Reset monitor: outputs must reach reset values without a clock edge.
  always @(posedge rst) begin
    if (rst_armed > 0) begin
      #1;
      rst_armed--;
      chk("rst_x0", x0, 0);       chk("rst_busy0", busy0, 0);  chk("rst_done0", done0, 0);
      chk("rst_onset0", on0, 0);  chk("rst_total0", tot0, 0);
      chk("rst_x2", x2, 0);       chk("rst_busy2", busy2, 0);  chk("rst_done2", done2, 0);
      chk("rst_onset2", on2, 0);  chk("rst_total2", tot2, 0);
`ifdef PLA_SWEEP_SIG_EN
      chk("rst_sig0", sig0, 16'hFFFF);
      chk("rst_sig2", sig2, 16'hFFFF);
`endif
    end
  end

  task automatic begin_start0(input logic [14:0] m, input logic [14:0] f, output int k);
    @(negedge clk);
    mask0 = m; fix0 = f; start0 = 1'b1;
    k = cyc + 1;
  endtask

  task automatic end_start0();
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    logic [15:0] sref;

    // Reset state
    #2;
    rst_armed++;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(2);

    // m=0: exactly one vector, f
    begin_start0(15'h0000, 15'h0001, k);
    q0.push_back(mk(k + 1, "t3_load", 1, 0, 0, 0, 0, 0));
    q0.push_back(mk(k + 2, "t3_vec", 1, 1, 0, 0, 1, 'h0001));
    q0.push_back(mk(k + 4, "t3_after", 0, 1, 1, 1, 1, 'h0001));
    d0.push_back(mkd(k + 3, "t3", 1, 1, 0, 0));
    end_start0();
    run(6);

    // PIPE=2, mask 0x0005, fixed 0x0010
    @(negedge clk);
    mask2 = 15'h0005; fix2 = 15'h0010; start2 = 1'b1;
    k = cyc + 1;
    q2.push_back(mk(k + 2, "t2_v0", 1, 1, 0, 0, 1, 'h10));
    q2.push_back(mk(k + 3, "t2_v1", 1, 1, 0, 0, 1, 'h11));
    q2.push_back(mk(k + 4, "t2_v2", 1, 0, 0, 0, 1, 'h14));
    q2.push_back(mk(k + 5, "t2_v3", 1, 1, 0, 1, 1, 'h15));
    q2.push_back(mk(k + 7, "t2_drain", 1, 0, 0, 0, 1, 'h15));
    q2.push_back(mk(k + 9, "t2_after", 0, 1, 2, 4, 1, 'h15));
    d2.push_back(mkd(k + 8, "t2", 2, 4, 0, 0));
    @(negedge clk);
    start2 = 1'b0;
    run(12);

    // Full 15-variable sweep, PIPE=0
    begin_start0(15'h7FFF, 15'h0000, k);
    q0.push_back(mk(k + 1002, "t1_mid", 1, 1, 500, 1000, 1, 1000));
    d0.push_back(mkd(k + 32770, "t1", 16384, 32768, 0, 0));
    end_start0();
    run(32775);

    // Abort on the 100th SWEEP cycle, then a fresh run
    begin_start0(15'h7FFF, 15'h0000, k);
    q0.push_back(mk(k + 102, "t4_abort", 0, 1, 50, 100, 0, 0));
    end_start0();
    run(100);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    run(3);
    begin_start0(15'h0003, 15'h0100, k);
    q0.push_back(mk(k + 2, "t4_fresh", 1, 1, 0, 0, 1, 'h100));
    d0.push_back(mkd(k + 6, "t4", 2, 4, 0, 0));
    end_start0();
    run(8);

`ifdef PLA_SWEEP_SIG_EN
    // Signature over 16 ones from seed 0xFFFF
    sref = 16'hFFFF;
    for (int i = 0; i < 16; i++) sref = misr_step(sref, 1'b1);
    y_force = 1'b1;
    begin_start0(15'h000F, 15'h0000, k);
    d0.push_back(mkd(k + 18, "tsig", 16, 16, 1, sref));
    end_start0();
    run(20);
    y_force = 1'b0;
`else
    sref = 16'h0000;
`endif

    // start during SWEEP is ignored; async reset mid-run
    begin_start0(15'h00FF, 15'h0000, k);
    q0.push_back(mk(k + 20, "t5_mid", 1, 1, 9, 18, 1, 'h12));
    end_start0();
    run(9);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    run(10);
    #2;
    rst_armed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run(5);

    chk("q0_pending", q0.size(), 0);
    chk("q2_pending", q2.size(), 0);
    chk("d0_pending", d0.size(), 0);
    chk("d2_pending", d2.size(), 0);
    chk("rst_pending", rst_armed, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
